sqrt_iter: RTL and testbench
============================

Name: sqrt_iter

Overview:
- Parametrised, multi-cycle integer square-root unit; next generation of the fixed 8-bit SquareRoot block.
- Computes Q = floor(sqrt(A)) and remainder R = A - Q*Q for unsigned A of configurable width.
- Retires ITER_PER_CYCLE result bits per clock using a start/done handshake.
- Sits in the datapath beside the other arithmetic units; consumers sample Q/R on done.

Parameters:
- WIDTH, 16, radicand width in bits; must be even and >= 4.
- ITER_PER_CYCLE, 1, root bits resolved per clock; legal values 1 or 2; WIDTH/2 must be divisible by it.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_  input  1  reset, synchronous, active-high (rst_=1 resets on the next rising edge).
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  unsigned radicand; captured on the accepted start.
- busy  output  1  high while in CALC.
- done  output  1  single-cycle pulse; Q/R are valid this cycle.
- Q  output  WIDTH/2  root.
- R  output  WIDTH/2+1  remainder, 0..2Q.

Behaviour:
- Let N = WIDTH/(2*ITER_PER_CYCLE) be the number of compute cycles.
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, Q=0, R=0.
  - Internal root, remainder and shift registers are cleared.
  - Reset has priority over all other inputs, including mid-calculation: the operation is abandoned and no done pulse is produced.
- States: IDLE and CALC.
- IDLE:
  - start=1 at edge k captures A, clears the working root and remainder, loads count=N, and moves to CALC.
  - busy=1 from edge k.
- CALC: each cycle performs ITER_PER_CYCLE iterations. One iteration is:
  - rem = (rem<<2) | next 2 MSBs of the radicand shift register.
  - trial = (root<<2) | 1.
  - If rem >= trial: rem = rem - trial and root = (root<<1) | 1.
  - Else: root = root<<1.
  - Working remainder is WIDTH/2+2 bits wide; no overflow is possible.
  - count decrements once per cycle.
  - When count reaches 1, the next edge (k+N) writes Q and R, pulses done=1 for exactly one cycle, sets busy=0, and returns to IDLE.
- Latency: done is high in the cycle after edge k+N (8 cycles for the defaults).
- Throughput: one result per N+1 cycles at most. start may be high in the done cycle and is accepted then (back-to-back operation).
- start while busy is ignored; A changes during CALC have no effect.
- Q/R hold their last result until the next completion. They do not change at start or during CALC.
- A=0 gives Q=0, R=0 after the normal latency; there is no early exit.

Optional Feature:
- Macro: SQRT_ROUND_EN.
- Defined:
  - Q is rounded to nearest: Q_out = Q + 1 when R > Q, otherwise Q. This is exact for sqrt(A) >= Q + 0.5.
  - Saturates at 2^(WIDTH/2)-1 when the increment would overflow.
  - R still reports the truncated remainder A - floor(sqrt(A))^2.
  - Rounding is folded into the completion edge; latency is unchanged.
- Undefined: Q is the truncated floor root; no rounding logic is present.

Test Plan:
- Defaults: rst_ high 2 cycles, then start with A=144 -> busy=1 for 8 cycles, done pulses one cycle later with Q=12, R=0. Reset values: all outputs 0 during rst_.
- Defaults: A=65535 -> Q=255, R=510. A=200 -> Q=14, R=4. A=0 -> Q=0, R=0, done still 8 cycles after start.
- Back-to-back: assert start in the done cycle with A=81 -> accepted; the next done gives Q=9, R=0. A start pulsed during CALC is ignored and produces no extra done.
- Mid-operation reset: start A=1000, assert rst_ at cycle 4 -> busy=0, Q=0, R=0, no done pulse. A following start with A=1000 gives Q=31, R=39.
- ITER_PER_CYCLE=2, WIDTH=16: A=50000 -> done after 4 cycles with Q=223, R=271. WIDTH=32, ITER_PER_CYCLE=1: A=4294967295 -> Q=65535, R=131070 after 16 cycles.
- SQRT_ROUND_EN defined, defaults:
  - A=210 -> Q=14 (R=14).
  - A=211 -> Q=15 (R=15).
  - A=65535 -> Q saturates at 255 (R=510).
  - A=200 -> Q=14.

Source files
------------

// File: rtl/sqrt_iter.sv
// Multi-cycle integer square root: Q = floor(sqrt(A)), R = A - Q*Q, ITER_PER_CYCLE root bits per clock.
// Optional SQRT_ROUND_EN: Q is rounded to nearest (saturating) at completion; R stays the truncated remainder.
module sqrt_iter #(
  parameter int WIDTH          = 16,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  output logic               busy,
  output logic               done,
  output logic [WIDTH/2-1:0] Q,
  output logic [WIDTH/2:0]   R
);

  localparam int QW = WIDTH / 2;
  localparam int RW = QW + 2;
  localparam int N  = WIDTH / (2 * ITER_PER_CYCLE);
  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [QW-1:0]   root_q, root_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [QW-1:0]   q_q, q_d;
  logic [QW:0]     r_q, r_d;
  logic            done_q, done_d;

  logic [WIDTH-1:0] rad_v;
  logic [QW-1:0]   root_v;
  logic [RW-1:0]   rem_v;
  logic [RW-1:0]   trial_v;
  logic [QW-1:0]   q_final;

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of its peers.
  // NOTE: reset is synchronous and clears every register, so an abandoned operation leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= IDLE;
      rad_q   <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC:    if (cnt_q == CW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Restoring square-root step, unrolled ITER_PER_CYCLE times per clock.
  always_comb begin
    rad_v   = rad_q;
    root_v  = root_q;
    rem_v   = rem_q;
    trial_v = '0;
    for (int i = 0; i < ITER_PER_CYCLE; i++) begin
      rem_v   = {rem_v[RW-3:0], rad_v[WIDTH-1 -: 2]};
      rad_v   = {rad_v[WIDTH-3:0], 2'b00};
      trial_v = {root_v, 2'b01};
      if (rem_v >= trial_v) begin
        rem_v  = rem_v - trial_v;
        root_v = {root_v[QW-2:0], 1'b1};
      end else begin
        root_v = {root_v[QW-2:0], 1'b0};
      end
    end
  end

`ifdef SQRT_ROUND_EN
  // R > Q means sqrt(A) >= Q + 0.5; an all-ones root cannot be incremented.
  always_comb begin
    q_final = root_v;
    if (rem_v > {2'b00, root_v} && !(&root_v)) q_final = root_v + QW'(1);
  end
`else
  assign q_final = root_v;
`endif

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    rad_d  = rad_q;
    root_d = root_q;
    rem_d  = rem_q;
    cnt_d  = cnt_q;
    q_d    = q_q;
    r_d    = r_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rad_d  = A;
          root_d = '0;
          rem_d  = '0;
          cnt_d  = CW'(N);
        end
      end
      CALC: begin
        rad_d  = rad_v;
        root_d = root_v;
        rem_d  = rem_v;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done_d = 1'b1;
          q_d    = q_final;
          r_d    = rem_v[QW:0];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = done_q;
    Q    = q_q;
    R    = r_q;
  end

endmodule

// File: tb/tb_sqrt_iter.sv
// Directed bench for sqrt_iter: default instance plus ITER_PER_CYCLE=2 and WIDTH=32 instances.
// Expected roots follow the rounded variant when SQRT_ROUND_EN is defined.
module tb_sqrt_iter;

`ifdef SQRT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_;
  logic        start;
  logic [15:0] a_in;
  logic        busy, done;
  logic [7:0]  q;
  logic [8:0]  r;

  logic        start2;
  logic [15:0] a2;
  logic        busy2, done2;
  logic [7:0]  q2;
  logic [8:0]  r2;

  logic        start3;
  logic [31:0] a3;
  logic        busy3, done3;
  logic [15:0] q3;
  logic [16:0] r3;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit seen;

  always #5 clk = ~clk;

  sqrt_iter #(.WIDTH(16), .ITER_PER_CYCLE(1)) dut (
    .clk(clk), .rst_(rst_), .start(start), .A(a_in),
    .busy(busy), .done(done), .Q(q), .R(r)
  );

  sqrt_iter #(.WIDTH(16), .ITER_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_(rst_), .start(start2), .A(a2),
    .busy(busy2), .done(done2), .Q(q2), .R(r2)
  );

  sqrt_iter #(.WIDTH(32), .ITER_PER_CYCLE(1)) dut3 (
    .clk(clk), .rst_(rst_), .start(start3), .A(a3),
    .busy(busy3), .done(done3), .Q(q3), .R(r3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [63:0] pick(input logic [63:0] trunc_q, input logic [63:0] rnd_q);
    return RND ? rnd_q : trunc_q;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch(input logic [15:0] a);
    start = 1'b1;
    a_in  = a;
    step();
    start = 1'b0;
    cyc   = 0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] eq, input logic [63:0] er);
    while (!done && cyc < 60) step();
    check({tag, "_latency"}, cyc, 8);
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_q"}, q, eq);
    check({tag, "_r"}, r, er);
  endtask

  initial begin
    rst_ = 1'b1; start = 1'b0; a_in = '0;
    start2 = 1'b0; a2 = '0; start3 = 1'b0; a3 = '0;
    step(); step();
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_q", q, 0);
    check("reset_r", r, 0);
    rst_ = 1'b0;
    step();

    launch(16'd144);
    wait_done("a144", 12, 0);
    step();
    check("done_single_pulse", done, 1'b0);
    check("q_holds", q, 12);

    launch(16'd65535);
    wait_done("a65535", 255, 510);
    launch(16'd0);
    wait_done("a0", 0, 0);
    launch(16'd210);
    wait_done("a210", 14, 14);
    launch(16'd211);
    wait_done("a211", pick(14, 15), 15);

    // Back-to-back: second start issued in the done cycle.
    launch(16'd200);
    wait_done("a200", 14, 4);
    launch(16'd81);
    check("q_unchanged_at_start", q, 14);
    wait_done("a81_b2b", 9, 0);

    // A start pulse and an A change during CALC must be ignored.
    launch(16'd49);
    step();
    start = 1'b1; a_in = 16'd9999;
    step();
    start = 1'b0;
    wait_done("a49_ignore", 7, 0);
    seen = 1'b0;
    repeat (12) begin step(); seen |= done; end
    check("no_extra_done", seen, 1'b0);

    // Reset in the middle of a calculation abandons it.
    launch(16'd1000);
    step(); step(); step();
    rst_ = 1'b1;
    step();
    check("midrst_busy", busy, 1'b0);
    check("midrst_q", q, 0);
    check("midrst_r", r, 0);
    rst_ = 1'b0;
    seen = done;
    repeat (12) begin step(); seen |= done; end
    check("midrst_no_done", seen, 1'b0);
    launch(16'd1000);
    wait_done("a1000", pick(31, 32), 39);

    // ITER_PER_CYCLE=2: four compute cycles.
    start2 = 1'b1; a2 = 16'd50000;
    step();
    start2 = 1'b0; cyc = 0;
    while (!done2 && cyc < 60) step();
    check("i2_latency", cyc, 4);
    check("i2_q", q2, pick(223, 224));
    check("i2_r", r2, 271);

    // WIDTH=32: sixteen compute cycles, rounding saturates.
    start3 = 1'b1; a3 = 32'hFFFF_FFFF;
    step();
    start3 = 1'b0; cyc = 0;
    while (!done3 && cyc < 60) step();
    check("w32_latency", cyc, 16);
    check("w32_q", q3, 65535);
    check("w32_r", r3, 131070);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
